// File: rtl/seq_detector_pkg.sv
// Shared constants for the programmable serial sequence detector: match modes,
// legal pattern widths and the pattern in force after reset.
package seq_detector_pkg;

  localparam logic MODE_NONOVL = 1'b0;
  localparam logic MODE_OVL    = 1'b1;

  localparam int PATTERN_W_MIN = 2;
  localparam int PATTERN_W_MAX = 16;

  localparam logic [3:0] DEFAULT_RESET_PATTERN = 4'b1001;

  // Width of a counter that must hold the values 0..max_val.
  function automatic int count_bits(input int max_val);
    int n;
    n = 1;
    while ((1 << n) <= max_val) n++;
    return n;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] MAX_VAL = {W{1'b1}};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != MAX_VAL)) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/seq_detector.sv
// Runtime-programmable Mealy serial pattern detector with overlapping and
// non-overlapping match modes, registered match copy and a match counter.
module seq_detector
  import seq_detector_pkg::*;
#(
  parameter int                   PATTERN_W     = 4,
  parameter int                   CNT_W         = 8,
  parameter logic [PATTERN_W-1:0] RESET_PATTERN = PATTERN_W'(DEFAULT_RESET_PATTERN)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 x,
  input  logic                 load,
  input  logic [PATTERN_W-1:0] pattern,
  input  logic                 overlap,
  input  logic                 count_clr,
  output logic                 y,
  output logic                 y_reg,
  output logic [CNT_W-1:0]     match_count
);

  localparam int HW = PATTERN_W - 1;
  localparam int FW = count_bits(PATTERN_W - 1);
  localparam logic [FW-1:0] FILL_MAX = FW'(PATTERN_W - 1);

  logic [HW-1:0]        hist_q;
  logic [FW-1:0]        fill_q;
  logic [PATTERN_W-1:0] pat_q;
  logic                 ovl_q;

  logic                 accept;
  logic                 full;
  logic [PATTERN_W-1:0] window;

  assign accept = en & ~load;
  assign full   = (fill_q == FILL_MAX);
  assign window = {hist_q, x};
  assign y      = accept & full & (window == pat_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist_q <= '0;
      fill_q <= '0;
      pat_q  <= RESET_PATTERN;
      ovl_q  <= MODE_OVL;
      y_reg  <= 1'b0;
    end else begin
      y_reg <= y;
      if (load) begin
        pat_q  <= pattern;
        ovl_q  <= overlap;
        hist_q <= '0;
        fill_q <= '0;
      end else if (en) begin
        hist_q <= window[HW-1:0];
        // A non-overlapping match discards the whole window so no bit is reused.
        if (y) begin
          if (ovl_q == MODE_NONOVL) fill_q <= '0;
        end else if (!full) begin
          fill_q <= fill_q + 1'b1;
        end
      end
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_match_count (
    .clk   (clk),
    .reset (reset),
    .clr   (count_clr),
    .inc   (y),
    .q     (match_count)
  );

endmodule

// File: tb/tb_seq_detector.sv
// Directed self-checking bench for seq_detector (4-bit pattern, 2-bit counter).
module tb_seq_detector;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b0;
  logic       x = 1'b0;
  logic       load = 1'b0;
  logic [3:0] pattern = 4'b0000;
  logic       overlap = 1'b0;
  logic       count_clr = 1'b0;
  logic       y;
  logic       y_reg;
  logic [1:0] match_count;

  int vectors = 0;
  int miscompares = 0;

  seq_detector #(
    .PATTERN_W(4),
    .CNT_W(2),
    .RESET_PATTERN(4'b1001)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .x           (x),
    .load        (load),
    .pattern     (pattern),
    .overlap     (overlap),
    .count_clr   (count_clr),
    .y           (y),
    .y_reg       (y_reg),
    .match_count (match_count)
  );

  always #5 clk = ~clk;

  // Apply one cycle of inputs on the falling edge; outputs are read 1 time unit later.
  task automatic drive(input logic ld, input logic [3:0] pat, input logic ov,
                       input logic e, input logic xb, input logic clr);
    @(negedge clk);
    load = ld; pattern = pat; overlap = ov; en = e; x = xb; count_clr = clr;
    #1;
    $display("t=%0t load=%0b pat=%b ovl=%0b en=%0b x=%0b clr=%0b -> y=%0b y_reg=%0b cnt=%0d",
             $time, ld, pat, ov, e, xb, clr, y, y_reg, match_count);
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    #1;
    vectors++;
    if (y !== 1'b0 || y_reg !== 1'b0 || match_count !== 2'd0) begin
      miscompares++;
      $display("FAIL reset_state: y=%b y_reg=%b cnt=%0d, want 0 0 0", y, y_reg, match_count);
    end
    @(negedge clk);
    reset = 1'b1;
    drive(0, 4'b0000, 0, 1, 1, 0);
    vectors++;
    if (y !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_empty_hist: y=%b want 0", y);
    end
  endtask

  // Feed a 7-bit stream (MSB first) under pattern 1011 and check y / y_reg per bit.
  task automatic run_1011(input logic ov, input logic [6:0] ye, input logic [1:0] cnt_exp,
                          input string nm);
    logic [6:0] xs;
    logic       prev;
    xs = 7'b1011011;
    drive(1, 4'b1011, ov, 1, 1, 1);
    vectors++;
    if (y !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_load_cycle: y=%b want 0", nm, y);
    end
    prev = 1'b0;
    for (int i = 6; i >= 0; i--) begin
      drive(0, 4'b0000, 0, 1, xs[i], 0);
      vectors++;
      if (y !== ye[i] || y_reg !== prev) begin
        miscompares++;
        $display("FAIL %s_bit%0d: y=%b y_reg=%b want y=%b y_reg=%b", nm, 7 - i, y, y_reg, ye[i], prev);
      end
      prev = ye[i];
    end
    drive(0, 4'b0000, 0, 0, 0, 0);
    vectors++;
    if (y_reg !== prev || match_count !== cnt_exp || y !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_count: y_reg=%b cnt=%0d y=%b want y_reg=%b cnt=%0d y=0",
               nm, y_reg, match_count, y, prev, cnt_exp);
    end
  endtask

  task automatic test_overlap;
    run_1011(1'b1, 7'b0001001, 2'd2, "overlap");
  endtask

  task automatic test_nonoverlap;
    run_1011(1'b0, 7'b0001000, 2'd1, "nonoverlap");
  endtask

  task automatic test_enable_gap;
    logic [4:0] es, xs, ye;
    es = 5'b11011; xs = 5'b10111; ye = 5'b00001;
    drive(1, 4'b1011, 1, 1, 0, 1);
    for (int i = 4; i >= 0; i--) begin
      drive(0, 4'b0000, 0, es[i], xs[i], 0);
      vectors++;
      if (y !== ye[i]) begin
        miscompares++;
        $display("FAIL enable_gap_step%0d: y=%b want %b", 5 - i, y, ye[i]);
      end
    end
    drive(0, 4'b0000, 0, 0, 0, 0);
    vectors++;
    if (match_count !== 2'd1) begin
      miscompares++;
      $display("FAIL enable_gap_count: cnt=%0d want 1", match_count);
    end
  endtask

  task automatic test_reload;
    logic [3:0] xs, ye;
    drive(1, 4'b1011, 1, 1, 0, 1);
    drive(0, 4'b0000, 0, 1, 1, 0);
    drive(0, 4'b0000, 0, 1, 0, 0);
    drive(0, 4'b0000, 0, 1, 1, 0);
    // Old pattern would match here; load must suppress it.
    drive(1, 4'b0110, 1, 1, 1, 0);
    vectors++;
    if (y !== 1'b0) begin
      miscompares++;
      $display("FAIL reload_load_cycle: y=%b want 0", y);
    end
    xs = 4'b0110; ye = 4'b0001;
    for (int i = 3; i >= 0; i--) begin
      drive(0, 4'b0000, 0, 1, xs[i], 0);
      vectors++;
      if (y !== ye[i]) begin
        miscompares++;
        $display("FAIL reload_bit%0d: y=%b want %b", 4 - i, y, ye[i]);
      end
    end
  endtask

  task automatic test_saturation;
    drive(1, 4'b1111, 1, 1, 0, 1);
    for (int i = 1; i <= 8; i++) begin
      drive(0, 4'b0000, 0, 1, 1, 0);
      vectors++;
      if (y !== (i >= 4)) begin
        miscompares++;
        $display("FAIL sat_bit%0d: y=%b want %b", i, y, (i >= 4));
      end
    end
    drive(0, 4'b0000, 0, 0, 0, 0);
    vectors++;
    if (match_count !== 2'd3) begin
      miscompares++;
      $display("FAIL sat_count: cnt=%0d want 3", match_count);
    end
    drive(0, 4'b0000, 0, 1, 1, 1);
    vectors++;
    if (y !== 1'b1) begin
      miscompares++;
      $display("FAIL clr_match_y: y=%b want 1", y);
    end
    drive(0, 4'b0000, 0, 0, 0, 0);
    vectors++;
    if (match_count !== 2'd0 || y_reg !== 1'b1) begin
      miscompares++;
      $display("FAIL clr_wins: cnt=%0d y_reg=%b want cnt=0 y_reg=1", match_count, y_reg);
    end
  endtask

  task automatic test_async_reset;
    logic [3:0] xs, ye;
    drive(1, 4'b1111, 1, 1, 0, 1);
    repeat (4) drive(0, 4'b0000, 0, 1, 1, 0);
    drive(0, 4'b0000, 0, 1, 1, 0);
    vectors++;
    if (y !== 1'b1 || y_reg !== 1'b1 || match_count !== 2'd1) begin
      miscompares++;
      $display("FAIL pre_reset: y=%b y_reg=%b cnt=%0d want 1 1 1", y, y_reg, match_count);
    end
    #2 reset = 1'b0;
    #1;
    vectors++;
    if (y !== 1'b0 || y_reg !== 1'b0 || match_count !== 2'd0) begin
      miscompares++;
      $display("FAIL async_reset: y=%b y_reg=%b cnt=%0d want 0 0 0", y, y_reg, match_count);
    end
    en = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    xs = 4'b1001; ye = 4'b0001;
    for (int i = 3; i >= 0; i--) begin
      drive(0, 4'b0000, 0, 1, xs[i], 0);
      vectors++;
      if (y !== ye[i]) begin
        miscompares++;
        $display("FAIL post_reset_bit%0d: y=%b want %b", 4 - i, y, ye[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_overlap();
    test_nonoverlap();
    test_enable_gap();
    test_reload();
    test_saturation();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
